// File: rtl/axi4_lite_mem_master_pkg.sv
// Shared types and constants for the AXI4-Lite memory master.
// Imported by the interface, the timeout counter and the top.
package axi4_lite_mem_master_pkg;

  localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI4_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RESP
  } state_e;

  function automatic logic resp_is_err(input logic [1:0] r);
    return (r == AXI4_RESP_SLVERR) || (r == AXI4_RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi4_lite_mem_master_if.sv
// AXI4-Lite bus bundle with master and slave views.
// 32-bit address and data, single-beat transfers only.
interface axi4_lite_mem_master_if;
  import axi4_lite_mem_master_pkg::*;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi4_lite_mem_master_timeout.sv
// Bus-wait watchdog: counts enabled cycles since the last clear.
// A limit of 0 disables it; also intended for the bus monitor.
module axi4_lite_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  import axi4_lite_mem_master_pkg::*;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q, cnt_d;

  assign expired_o = (LIMIT != 16'd0) && enable_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi4_lite_mem_master.sv
// Single-outstanding LSU request to AXI4-Lite read/write bridge.
// All bus and response outputs are registered; timeout aborts.
module axi4_lite_mem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  axi4_lite_mem_master_if.master bus
);
  import axi4_lite_mem_master_pkg::*;

  state_e      state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic [31:0] awaddr_q;
  logic [31:0] araddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        aw_done_q;
  logic        w_done_q;

  logic accept;
  logic busy;
  logic expired;
  logic aw_hs;
  logic w_hs;

  assign accept = req_valid && req_ready_q;
  assign busy   = (state_q == S_WR) || (state_q == S_WR_RESP) ||
                  (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
  assign aw_hs  = awvalid_q && bus.awready;
  assign w_hs   = wvalid_q && bus.wready;

  axi4_lite_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (accept),
    .enable_i (busy),
    .expired_o(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (busy && expired) begin
        // Abandon the bus; late responses are never acknowledged.
        awvalid_q    <= 1'b0;
        wvalid_q     <= 1'b0;
        bready_q     <= 1'b0;
        arvalid_q    <= 1'b0;
        rready_q     <= 1'b0;
        resp_err_q   <= 1'b1;
        resp_rdata_q <= '0;
        resp_valid_q <= 1'b1;
        state_q      <= S_RESP;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (accept) begin
              req_ready_q <= 1'b0;
              if (req_we) begin
                awaddr_q  <= req_addr;
                wdata_q   <= req_wdata;
                wstrb_q   <= req_wstrb;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                state_q   <= S_WR;
              end else begin
                araddr_q  <= req_addr;
                arvalid_q <= 1'b1;
                state_q   <= S_RD_ADDR;
              end
            end
          end
          S_WR: begin
            if (aw_hs) begin
              awvalid_q <= 1'b0;
              aw_done_q <= 1'b1;
            end
            if (w_hs) begin
              wvalid_q <= 1'b0;
              w_done_q <= 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
              bready_q <= 1'b1;
              state_q  <= S_WR_RESP;
            end
          end
          S_WR_RESP: begin
            if (bus.bvalid) begin
              bready_q     <= 1'b0;
              resp_err_q   <= resp_is_err(bus.bresp);
              resp_rdata_q <= '0;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end
          end
          S_RD_ADDR: begin
            if (bus.arready) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state_q   <= S_RD_DATA;
            end
          end
          S_RD_DATA: begin
            if (bus.rvalid) begin
              rready_q     <= 1'b0;
              resp_err_q   <= resp_is_err(bus.rresp);
              resp_rdata_q <= bus.rdata;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end
          end
          S_RESP: begin
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
          default: begin
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign bus.awaddr  = awaddr_q;
  assign bus.awvalid = awvalid_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = bready_q;
  assign bus.araddr  = araddr_q;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

endmodule

// File: doc/axi4_lite_mem_master.md
# axi4_lite_mem_master

AXI4-Lite initiator that turns the CPU load/store unit's single-outstanding memory request into AXI4-Lite read or write transactions. It sits between the core's LSU/IFU request port and the AXI4-Lite interconnect that feeds the peripheral slaves (UART, timer, SRAM). It handles one transaction at a time, tracks the AW and W channels independently, and returns the read data or error to the core. A programmable timeout converts a hung bus into an error response.

## Interface
- TIMEOUT_CYCLES, default 1024: bus-wait limit in cycles; 0 disables the timeout. Must satisfy 0 ≤ TIMEOUT_CYCLES < 2^16.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  high only in IDLE; the request is accepted on req_valid & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address, passed to the bus unmodified.
- req_wdata  in  32  write data, lane-aligned by the CPU.
- req_wstrb  in  4  byte strobes; ignored for reads.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  read data; 0 for writes and on timeout.
- resp_err  out  1  set to xRESP[1] (SLVERR/DECERR), or 1 on timeout.
- Master ports  `AXI4_LITE_MASTER_PORTS`: awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready, all 32-bit data and address.

## Operation
- States: IDLE, WR (AW+W pending), WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch addr, wdata and wstrb, then go to WR if req_we, else RD_ADDR.
- WR:
  - awvalid and wvalid assert together.
  - Each valid drops the cycle after its own handshake (aw_done and w_done flags).
  - Handshakes may occur in the same cycle or in either order.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid, capture bresp[1] into resp_err, then go to RESP.
- RD_ADDR:
  - arvalid=1 until arready, then go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid, capture rdata and rresp[1], then go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - The core must always accept the response; there is no back-pressure.
- Valid signals:
  - Never depend combinationally on any ready input.
  - Once asserted, a valid holds with stable address/data until its handshake.
  - The timeout is the only exception.
- Timeout:
  - A 16-bit counter clears on accept and increments every cycle in WR, WR_RESP, RD_ADDR and RD_DATA.
  - When it reaches TIMEOUT_CYCLES, all valids and readies drop on the next edge.
  - The block then goes to RESP with resp_err=1 and resp_rdata=0.
  - Late bvalid or rvalid arriving afterwards is ignored: bready and rready stay 0 outside their states.
- Unknown state: the block returns to IDLE.

## Timing
- Reset:
  - state=IDLE.
  - req_ready=1 on the first cycle after reset.
  - All *valid and *ready outputs are 0.
  - resp_valid=0, resp_err=0, resp_rdata=0, awaddr=araddr=wdata=0, wstrb=0.
- Reset mid-transaction: outputs return to their reset values on the next edge; no resp_valid is generated.
- Write latency: accept at cycle 0; awvalid and wvalid high at cycle 1.
  - Zero-wait slave (ready at cycle 1, bvalid at cycle 2): bready handshake at 2, resp_valid at 3.
  - Minimum write latency is 3 cycles from accept.
- Read latency: accept at 0; arvalid at 1.
  - arready at 1 and rvalid at 2: rready handshake at 2, resp_valid at 3.
- req_ready is low from the cycle after accept until the cycle after resp_valid.
  - A back-to-back request is therefore accepted at cycle 4 at the earliest.
- The timeout fires when the counter equals TIMEOUT_CYCLES. resp_valid follows TIMEOUT_CYCLES+2 cycles after accept.

## Structure
- The shared header axi4_lite_interface.vh owns:
  - the `AXI4_RESP_OKAY/EXOKAY/SLVERR/DECERR` constants;
  - the `AXI4_LITE_MASTER_PORTS` macro, which is added there and mirrors the slave macro with directions inverted.
- State encodings are module-local localparams.
- One sub-module: axi4_lite_timeout.
  - Inputs: clear and enable.
  - Output: expired.
  - Parameter: TIMEOUT_CYCLES; it is reused by the future bus monitor.

## Test plan
- Write 0x000000AB, wstrb=0001, to 0xA00003F8 with a zero-wait slave:
  - awvalid and wvalid are high together at cycle 1;
  - resp_valid at cycle 3 with resp_err=0.
- Write where wready arrives 3 cycles before awready:
  - wvalid drops after its handshake;
  - awvalid holds with a stable address;
  - exactly one write reaches the slave.
- Read of 0x80000000, slave returns rdata=0xDEADBEEF after 5 wait cycles:
  - resp_rdata=0xDEADBEEF, resp_err=0;
  - rready is high only in RD_DATA.
- Read answered with rresp=DECERR: resp_err=1 and resp_rdata equals the bus rdata.
- TIMEOUT_CYCLES=8, slave never raises arready:
  - arvalid drops;
  - resp_valid with resp_err=1 and rdata=0 at cycle 10;
  - a late rvalid is ignored.
- rst pulsed while in WR_RESP:
  - all outputs return to reset values next cycle;
  - no resp_valid;
  - the next request completes normally.
